// File: rtl/wb_soc_slave_pkg.sv
// Register map and STATUS layout shared by the Video-In Wishbone register slave.
package wb_soc_slave_pkg;

    localparam logic [1:0] REG_ADDR     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_IRQ_CTRL = 2'd2;
    localparam logic [1:0] REG_IRQ_ACK  = 2'd3;

    localparam int unsigned STATUS_INIT_BIT = 0;
    localparam int unsigned STATUS_PEND_BIT = 1;
    localparam int unsigned STATUS_EN_BIT   = 2;

    function automatic logic [31:0] status_word(input logic init, input logic pend,
                                                input logic en);
        logic [31:0] w;
        w                  = '0;
        w[STATUS_INIT_BIT] = init;
        w[STATUS_PEND_BIT] = pend;
        w[STATUS_EN_BIT]   = en;
        return w;
    endfunction

endpackage

// File: rtl/wb_soc_irq_ctrl.sv
// Rising-edge interrupt capture with a maskable, software-acknowledged pending bit
// and a registered interrupt output.
module wb_soc_irq_ctrl #(
    parameter logic IRQ_EN_RESET = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raise_irq,
    input  logic en_we,
    input  logic en_wdata,
    input  logic ack_clr,
    output logic pending,
    output logic enable,
    output logic irq
);

    logic raise_q;
    logic set_evt;

    assign set_evt = raise_irq & ~raise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raise_q <= 1'b0;
            pending <= 1'b0;
            enable  <= IRQ_EN_RESET;
            irq     <= 1'b0;
        end else begin
            raise_q <= raise_irq;
            // A new event beats a simultaneous acknowledge so no edge is lost.
            if (set_evt) begin
                pending <= 1'b1;
            end else if (ack_clr) begin
                pending <= 1'b0;
            end
            if (en_we) begin
                enable <= en_wdata;
            end
            irq <= pending & enable;
        end
    end

endmodule

// File: rtl/wb_soc_reg_slave.sv
// Wishbone classic register slave for Video-In: frame-buffer address, status and interrupt.
// Interrupt logic is built only when WB_SOC_SLAVE_IRQ_EN is defined.
module wb_soc_reg_slave
    import wb_soc_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_RESET   = 32'h0000_0000,
    parameter logic        IRQ_EN_RESET = 1'b1
) (
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic        raise_irq,
    output logic        irq,
    output logic [31:0] module_register,
    output logic        initialized,
    input  logic [31:0] p_wb_DAT_I,
    output logic [31:0] p_wb_DAT_O,
    input  logic [31:0] p_wb_ADR_I,
    output logic        p_wb_ACK_O,
    input  logic        p_wb_CYC_I,
    output logic        p_wb_ERR_O,
    input  logic        p_wb_LOCK_I,
    output logic        p_wb_RTY_O,
    input  logic [3:0]  p_wb_SEL_I,
    input  logic        p_wb_STB_I,
    input  logic        p_wb_WE_I
);

    logic [1:0]  off;
    logic        req;
    logic        wr;
    logic        rd;
    logic        ack_q;
    logic [31:0] dat_o_q;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic        init_q;
    logic [31:0] rdata;
    logic        pending;
    logic        enable;
    logic        unused;

    assign off = p_wb_ADR_I[3:2];
    // ACK in flight blocks re-execution, so a held strobe completes every second cycle.
    assign req = p_wb_CYC_I & p_wb_STB_I & ~ack_q;
    assign wr  = req & p_wb_WE_I;
    assign rd  = req & ~p_wb_WE_I;

`ifdef WB_SOC_SLAVE_IRQ_EN
    logic en_we;
    logic ack_clr;

    assign en_we   = wr & (off == REG_IRQ_CTRL) & p_wb_SEL_I[0];
    assign ack_clr = wr & (off == REG_IRQ_ACK) & p_wb_SEL_I[0] & p_wb_DAT_I[0];

    wb_soc_irq_ctrl #(
        .IRQ_EN_RESET (IRQ_EN_RESET)
    ) u_irq_ctrl (
        .clk       (p_clk),
        .rst_n     (p_resetn),
        .raise_irq (raise_irq),
        .en_we     (en_we),
        .en_wdata  (p_wb_DAT_I[0]),
        .ack_clr   (ack_clr),
        .pending   (pending),
        .enable    (enable),
        .irq       (irq)
    );

    assign unused = ^{p_wb_ADR_I[31:4], p_wb_ADR_I[1:0], p_wb_LOCK_I};
`else
    assign pending = 1'b0;
    assign enable  = 1'b0;
    assign irq     = 1'b0;
    assign unused  = ^{p_wb_ADR_I[31:4], p_wb_ADR_I[1:0], p_wb_LOCK_I, raise_irq,
                       IRQ_EN_RESET};
`endif

    always_comb begin
        addr_d = addr_q;
        if (wr && (off == REG_ADDR)) begin
            for (int b = 0; b < 4; b++) begin
                if (p_wb_SEL_I[b]) begin
                    addr_d[8*b +: 8] = p_wb_DAT_I[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            REG_ADDR:     rdata = addr_q;
            REG_STATUS:   rdata = status_word(init_q, pending, enable);
            REG_IRQ_CTRL: rdata = {31'b0, enable};
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            ack_q   <= 1'b0;
            dat_o_q <= '0;
            addr_q  <= ADDR_RESET;
            init_q  <= 1'b0;
        end else begin
            ack_q  <= req;
            addr_q <= addr_d;
            if (rd) begin
                dat_o_q <= rdata;
            end
            if (wr && (off == REG_ADDR) && (|p_wb_SEL_I)) begin
                init_q <= 1'b1;
            end
        end
    end

    assign p_wb_ACK_O      = ack_q;
    assign p_wb_DAT_O      = dat_o_q;
    assign p_wb_ERR_O      = 1'b0;
    assign p_wb_RTY_O      = 1'b0;
    assign module_register = addr_q;
    assign initialized     = init_q;

endmodule

// File: tb/tb_wb_soc_reg_slave.sv
// Scoreboard bench for wb_soc_reg_slave: bus accesses queue their expected responses,
// a negedge monitor retires them on every ACK.
module tb_wb_soc_reg_slave;

    logic        p_clk = 1'b0;
    logic        p_resetn;
    logic        raise_irq;
    logic        irq;
    logic [31:0] module_register;
    logic        initialized;
    logic [31:0] p_wb_DAT_I;
    logic [31:0] p_wb_DAT_O;
    logic [31:0] p_wb_ADR_I;
    logic        p_wb_ACK_O;
    logic        p_wb_CYC_I;
    logic        p_wb_ERR_O;
    logic        p_wb_LOCK_I;
    logic        p_wb_RTY_O;
    logic [3:0]  p_wb_SEL_I;
    logic        p_wb_STB_I;
    logic        p_wb_WE_I;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t drop_e;
    int   checks = 0;
    int   errors = 0;
    int   acks;

`ifdef WB_SOC_SLAVE_IRQ_EN
    localparam logic [31:0] EN_BIT = 32'h4;
`else
    localparam logic [31:0] EN_BIT = 32'h0;
`endif

    wb_soc_reg_slave dut (
        .p_clk           (p_clk),
        .p_resetn        (p_resetn),
        .raise_irq       (raise_irq),
        .irq             (irq),
        .module_register (module_register),
        .initialized     (initialized),
        .p_wb_DAT_I      (p_wb_DAT_I),
        .p_wb_DAT_O      (p_wb_DAT_O),
        .p_wb_ADR_I      (p_wb_ADR_I),
        .p_wb_ACK_O      (p_wb_ACK_O),
        .p_wb_CYC_I      (p_wb_CYC_I),
        .p_wb_ERR_O      (p_wb_ERR_O),
        .p_wb_LOCK_I     (p_wb_LOCK_I),
        .p_wb_RTY_O      (p_wb_RTY_O),
        .p_wb_SEL_I      (p_wb_SEL_I),
        .p_wb_STB_I      (p_wb_STB_I),
        .p_wb_WE_I       (p_wb_WE_I)
    );

    always #5 p_clk = ~p_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    // Retire one scoreboard entry per ACK; reads also compare the returned data.
    always @(negedge p_clk) begin
        if (p_wb_ACK_O === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard expected no ack");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_read && (p_wb_DAT_O !== mon_e.data)) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h", p_wb_DAT_O, mon_e.data);
                end
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic [31:0] exp_rd);
        sb.push_back(exp_t'{is_read: ~we, data: exp_rd});
        tick();
        p_wb_CYC_I = 1'b1;
        p_wb_STB_I = 1'b1;
        p_wb_WE_I  = we;
        p_wb_ADR_I = adr;
        p_wb_DAT_I = wdat;
        p_wb_SEL_I = sel;
        tick();
        check("ack_latency", 32'(p_wb_ACK_O), 32'd1);
        if (p_wb_ACK_O !== 1'b1) begin
            drop_e = sb.pop_back();
        end
        p_wb_CYC_I = 1'b0;
        p_wb_STB_I = 1'b0;
        p_wb_WE_I  = 1'b0;
        tick();
        check("ack_one_cycle", 32'(p_wb_ACK_O), 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat,
                            input logic [3:0] sel);
        wb_xfer(1'b1, adr, wdat, sel, 32'h0);
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp_rd);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        p_resetn    = 1'b0;
        raise_irq   = 1'b0;
        p_wb_DAT_I  = '0;
        p_wb_ADR_I  = '0;
        p_wb_CYC_I  = 1'b0;
        p_wb_LOCK_I = 1'b0;
        p_wb_SEL_I  = '0;
        p_wb_STB_I  = 1'b0;
        p_wb_WE_I   = 1'b0;
        #22;
        check("rst_ack", 32'(p_wb_ACK_O), 32'd0);
        check("rst_dat_o", p_wb_DAT_O, 32'h0);
        check("rst_err", 32'(p_wb_ERR_O), 32'd0);
        check("rst_rty", 32'(p_wb_RTY_O), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_addr", module_register, 32'h0);
        check("rst_init", 32'(initialized), 32'd0);
        #5;
        p_resetn = 1'b1;

        wb_read(32'h4, EN_BIT);
        wb_write(32'h0, 32'h4100_0000, 4'hF);
        check("addr_full", module_register, 32'h4100_0000);
        check("init_set", 32'(initialized), 32'd1);
        wb_read(32'h0, 32'h4100_0000);
        wb_write(32'h0, 32'hAABB_CCDD, 4'b0010);
        check("addr_byte1", module_register, 32'h4100_CC00);
        wb_read(32'h0, 32'h4100_CC00);
        wb_read(32'h4, EN_BIT | 32'h1);

`ifdef WB_SOC_SLAVE_IRQ_EN
        tick();
        raise_irq = 1'b1;
        tick();
        check("irq_edge_plus1", 32'(irq), 32'd0);
        tick();
        check("irq_edge_plus2", 32'(irq), 32'd1);
        repeat (3) tick();
        check("irq_stays", 32'(irq), 32'd1);
        wb_read(32'h4, 32'h7);
        wb_write(32'hC, 32'h1, 4'h1);
        check("irq_acked", 32'(irq), 32'd0);
        tick();
        tick();
        check("held_one_event", 32'(irq), 32'd0);
        raise_irq = 1'b0;
        wb_read(32'h4, 32'h5);

        wb_write(32'h8, 32'h0, 4'h1);
        wb_read(32'h4, 32'h1);
        raise_irq = 1'b1;
        repeat (3) tick();
        check("irq_masked", 32'(irq), 32'd0);
        raise_irq = 1'b0;
        wb_read(32'h4, 32'h3);
        wb_write(32'h8, 32'h1, 4'hE);
        wb_read(32'h8, 32'h0);
        wb_write(32'h8, 32'h1, 4'h1);
        check("irq_unmasked", 32'(irq), 32'd1);
        wb_read(32'h8, 32'h1);
        wb_read(32'hC, 32'h0);
        wb_write(32'hC, 32'h1, 4'hE);
        check("ack_needs_sel0", 32'(irq), 32'd1);
        wb_write(32'hC, 32'h1, 4'h1);
        check("irq_cleared", 32'(irq), 32'd0);
`else
        tick();
        raise_irq = 1'b1;
        repeat (4) tick();
        check("irq_tied_low", 32'(irq), 32'd0);
        raise_irq = 1'b0;
        wb_write(32'h8, 32'h1, 4'hF);
        wb_read(32'h8, 32'h0);
        wb_write(32'hC, 32'h1, 4'hF);
        check("irq_still_low", 32'(irq), 32'd0);
`endif

        wb_write(32'h4, 32'hFFFF_FFFF, 4'hF);
        wb_read(32'h4, EN_BIT | 32'h1);
        check("addr_after_status_wr", module_register, 32'h4100_CC00);

        // Held strobe for six edges: accesses complete on every second one.
        tick();
        repeat (3) sb.push_back(exp_t'{is_read: 1'b1, data: 32'h4100_CC00});
        p_wb_CYC_I = 1'b1;
        p_wb_STB_I = 1'b1;
        p_wb_WE_I  = 1'b0;
        p_wb_ADR_I = 32'h0;
        acks = 0;
        repeat (6) begin
            tick();
            if (p_wb_ACK_O === 1'b1) acks++;
        end
        p_wb_CYC_I = 1'b0;
        p_wb_STB_I = 1'b0;
        check("burst_acks", 32'(acks), 32'd3);
        tick();

        // Reset in the middle of an acknowledged cycle, with a write still being presented.
        p_wb_CYC_I = 1'b1;
        p_wb_STB_I = 1'b1;
        p_wb_WE_I  = 1'b0;
        p_wb_ADR_I = 32'h0;
        tick();
        check("ack_before_reset", 32'(p_wb_ACK_O), 32'd1);
        p_wb_WE_I  = 1'b1;
        p_wb_DAT_I = 32'h1234_5678;
        p_wb_SEL_I = 4'hF;
        #1;
        p_resetn = 1'b0;
        #1;
        check("mid_rst_ack", 32'(p_wb_ACK_O), 32'd0);
        check("mid_rst_dat_o", p_wb_DAT_O, 32'h0);
        check("mid_rst_addr", module_register, 32'h0);
        check("mid_rst_init", 32'(initialized), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        tick();
        check("write_discarded", module_register, 32'h0);
        p_wb_CYC_I = 1'b0;
        p_wb_STB_I = 1'b0;
        p_wb_WE_I  = 1'b0;
        #3;
        p_resetn = 1'b1;
        tick();
        check("post_rst_addr", module_register, 32'h0);
        wb_read(32'h4, EN_BIT);

        repeat (2) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
